// File: rtl/sim_sram_pkg.sv
// Shared types, counter width and address-window decode helper for the simulation SRAM window.
package sim_sram_pkg;

    localparam int CNT_W   = 16;
    localparam int SRAM_DW = 32;

    typedef struct packed {
        logic               err;
        logic [SRAM_DW-1:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic                 we;
        logic [31:0]          addr;
        logic [SRAM_DW-1:0]   wdata;
        logic [SRAM_DW/8-1:0] be;
    } req_t;

    // One bit wider than any supported address so a window ending at 2**AW cannot wrap.
    function automatic logic in_window(input logic [64:0] addr,
                                       input logic [64:0] base,
                                       input logic [64:0] bytes);
        return (addr >= base) && (addr < base + bytes);
    endfunction

endpackage

// File: rtl/sim_sram_lat_pipe.sv
// Fixed-latency delay line for responses: STAGES registers, valid bits asynchronously cleared.
module sim_sram_lat_pipe #(
    parameter int STAGES = 1,
    parameter int W      = 33
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic         src_vld;
        logic [W-1:0] src_dat;
        logic         vld;
        logic [W-1:0] dat;

        if (gi == 0) begin : g_src
            assign src_vld = in_valid;
            assign src_dat = in_data;
        end else begin : g_src
            assign src_vld = g_stage[gi-1].vld;
            assign src_dat = g_stage[gi-1].dat;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld <= 1'b0;
            end else begin
                vld <= src_vld;
            end
        end

        // Payload needs no reset; it is only observed alongside its valid bit.
        always_ff @(posedge clk_i) begin
            if (src_vld) begin
                dat <= src_dat;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign out_data  = g_stage[STAGES-1].dat;

endmodule

// File: rtl/sim_sram_window.sv
// Memory-mapped scratch SRAM responder: req/gnt in, in-order rvalid/rready responses out,
// byte-enable writes, out-of-window/misaligned error responses and saturating hit/error counters.
module sim_sram_window
    import sim_sram_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            DEPTH      = 1024,
    parameter logic [AW-1:0] START_ADDR = 32'h1000_0000,
    parameter int            RD_LAT     = 1,
    parameter int            RSP_DEPTH  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [DW/8-1:0]  be_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [DW-1:0]    rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int NB = DW / 8;
    localparam int AB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [64:0] WIN_BASE  = 65'(START_ADDR);
    localparam logic [64:0] WIN_BYTES = 65'(DEPTH) * 65'(NB);

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } win_rsp_t;

    logic           hit;
    logic           xfer;
    logic           pop;
    logic [IW-1:0]  idx;
    logic           pipe_valid;
    win_rsp_t       pipe_in;
    win_rsp_t       pipe_out;
    win_rsp_t       head;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;

    logic [DW-1:0]    mem [DEPTH];
    win_rsp_t         fifo_mem [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    fifo_cnt_reg, fifo_cnt_next;
    logic [CW-1:0]    out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0] hit_cnt_reg, err_cnt_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign hit = in_window(65'(addr_i), WIN_BASE, WIN_BYTES) && (addr_i[AB-1:0] == '0);
    assign idx = IW'((addr_i - START_ADDR) >> AB);

    // A slot freed by this cycle's pop may be re-granted in the same cycle.
    assign pop   = rvalid_o && rready_i;
    assign gnt_o = req_i && rst_ni && ((out_cnt_reg < CW'(RSP_DEPTH)) || pop);
    assign xfer  = gnt_o;

    always_ff @(posedge clk_i) begin
        if (xfer && hit && we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // The first pipe stage is the read register, so read data is fixed at the grant edge.
    always_comb begin
        pipe_in       = '0;
        pipe_in.err   = !hit;
        pipe_in.rdata = (hit && !we_i) ? mem[idx] : '0;
    end

    sim_sram_lat_pipe #(
        .STAGES (RD_LAT),
        .W      ($bits(win_rsp_t))
    ) u_lat_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (xfer),
        .in_data   (pipe_in),
        .out_valid (pipe_valid),
        .out_data  (pipe_out)
    );

    // Fall-through FIFO: an arriving response is presented directly when the FIFO is empty.
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign head       = fifo_empty ? pipe_out : fifo_mem[rd_ptr_reg];
    assign rvalid_o   = !fifo_empty || pipe_valid;
    assign rdata_o    = rvalid_o ? head.rdata : '0;
    assign err_o      = rvalid_o && head.err;
    assign fifo_push  = pipe_valid && !(fifo_empty && rready_i);
    assign fifo_pop   = pop && !fifo_empty;

    always_comb begin
        fifo_cnt_next = fifo_cnt_reg;
        out_cnt_next  = out_cnt_reg;
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_next = fifo_cnt_reg + CW'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_next = fifo_cnt_reg - CW'(1);
        end
        if (xfer && !pop) begin
            out_cnt_next = out_cnt_reg + CW'(1);
        end else if (!xfer && pop) begin
            out_cnt_next = out_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            out_cnt_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            fifo_cnt_reg <= fifo_cnt_next;
            out_cnt_reg  <= out_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= pipe_out;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else if (xfer) begin
            if (hit && hit_cnt_reg != '1) begin
                hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end
            if (!hit && err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign hit_cnt_o = hit_cnt_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule
